// File: rtl/eq_pkg.sv
// Shared definitions for the equalizer datapath: sequencer state encoding
// and the default geometry used by the sample queue and the band FIR engines.
package eq_pkg;

    localparam int DATA_W      = 16;
    localparam int NTAPS_DEF   = 1021;
    localparam int QDEPTH_DEF  = 1024;
    localparam int FIR_LAT_DEF = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        WAIT = 2'd2,
        CAPT = 2'd3
    } seq_state_t;

endpackage

// File: rtl/fir_tap_ctr.sv
// Tap counter and circular read-address generator for one FIR run.
// k walks 0..NTAPS-1 and parks on the last tap; rd_addr is (start + k)
// modulo QDEPTH, so it keeps showing the last address used outside a run.
module fir_tap_ctr #(
    parameter  int NTAPS  = 1021,
    parameter  int QDEPTH = 1024,
    localparam int AW     = $clog2(QDEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [AW-1:0] start_in,
    input  logic          adv,
    output logic          last,
    output logic [AW-1:0] rd_addr
);

    localparam int          KW = (NTAPS > 1) ? $clog2(NTAPS) : 1;
    localparam logic [AW:0] QD = (AW + 1)'(QDEPTH);

    logic [AW-1:0] start;
    logic [KW-1:0] k;
    logic [AW:0]   sum;

    // Latch the run origin and restart k on load; otherwise step k until the last tap.
    always_ff @(posedge clk) begin
        if (rst) begin
            start <= '0;
            k     <= '0;
        end else if (load) begin
            start <= start_in;
            k     <= '0;
        end else if (adv && !last) begin
            k <= k + 1'b1;
        end
    end

    // Modular address: one extra bit of headroom, fold back by QDEPTH on overflow.
    always_comb begin
        last    = (k == KW'(NTAPS - 1));
        sum     = {1'b0, start} + {{(AW + 1 - KW){1'b0}}, k};
        rd_addr = (sum >= QD) ? AW'(sum - QD) : AW'(sum);
    end

endmodule

// File: rtl/fir_seq_ctrl.sv
// Sequencer for one band FIR engine: walks the queue read address over the
// oldest NTAPS samples per request, waits out the engine latency, then
// registers the engine result with a one-cycle valid pulse. One request may
// be held pending during a run; a pending request that gets replaced sets
// the sticky overrun flag.
module fir_seq_ctrl
    import eq_pkg::*;
#(
    parameter  int NTAPS   = NTAPS_DEF,
    parameter  int QDEPTH  = QDEPTH_DEF,
    parameter  int FIR_LAT = FIR_LAT_DEF,
    localparam int AW      = $clog2(QDEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     smpl_rdy,
    input  logic                     q_full,
    input  logic [AW-1:0]            wr_ptr,
    input  logic                     clr_ovr,
    input  logic signed [DATA_W-1:0] fir_out,
    output logic                     sequencing,
    output logic [AW-1:0]            rd_addr,
    output logic signed [DATA_W-1:0] smpl_out,
    output logic                     smpl_vld,
    output logic                     busy,
    output logic                     overrun
);

    localparam int WW = (FIR_LAT > 1) ? $clog2(FIR_LAT) : 1;

    seq_state_t    state, state_nxt;
    logic          pend;
    logic [AW-1:0] pend_ptr;
    logic [WW-1:0] wcnt;
    logic          last;
    logic          load;
    logic [AW-1:0] start_sel;
    logic          wait_done;
    logic          consume;
    logic          take_req;
    logic          ovr_set;

    fir_tap_ctr #(
        .NTAPS  (NTAPS),
        .QDEPTH (QDEPTH)
    ) u_tap_ctr (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .start_in (start_sel),
        .adv      (state == RUN),
        .last     (last),
        .rd_addr  (rd_addr)
    );

    // Outputs decoded from registered state only.
    assign sequencing = (state == RUN);
    assign busy       = (state != IDLE);
    assign wait_done  = (wcnt == WW'(FIR_LAT - 1));

    // Pending bookkeeping. A request landing in CAPT right after the pend slot
    // was found empty is kept in the slot and started from IDLE on the next
    // cycle, so it is never silently stranded.
    always_comb begin
        consume  = pend && ((state == CAPT) || (state == IDLE));
        take_req = smpl_rdy && ((state != IDLE) || pend);
        ovr_set  = take_req && pend && !consume;
    end

    // Next-state and run-start decode.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        start_sel = wr_ptr;
        case (state)
            IDLE: begin
                if (pend) begin
                    load      = 1'b1;
                    start_sel = pend_ptr;
                    state_nxt = RUN;
                end else if (smpl_rdy && q_full) begin
                    load      = 1'b1;
                    start_sel = wr_ptr;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last) state_nxt = WAIT;
            end
            WAIT: begin
                if (wait_done) state_nxt = CAPT;
            end
            CAPT: begin
                if (pend) begin
                    load      = 1'b1;
                    start_sel = pend_ptr;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Engine latency counter, running only while in WAIT.
    always_ff @(posedge clk) begin
        if (rst || (state != WAIT)) wcnt <= '0;
        else                        wcnt <= wcnt + 1'b1;
    end

    // Pending slot: newest request wins, consumed slot frees on run start.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend     <= 1'b0;
            pend_ptr <= '0;
        end else if (take_req) begin
            pend     <= 1'b1;
            pend_ptr <= wr_ptr;
        end else if (consume) begin
            pend     <= 1'b0;
        end
    end

    // Sticky overrun; a new drop wins over a clear in the same cycle.
    always_ff @(posedge clk) begin
        if (rst)          overrun <= 1'b0;
        else if (ovr_set) overrun <= 1'b1;
        else if (clr_ovr) overrun <= 1'b0;
    end

    // Result capture register and valid pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            smpl_out <= '0;
            smpl_vld <= 1'b0;
        end else begin
            smpl_vld <= (state == CAPT);
            if (state == CAPT) smpl_out <= fir_out;
        end
    end

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Bench for fir_seq_ctrl at NTAPS=8, QDEPTH=16, FIR_LAT=1: directed
// scenarios followed by a randomized run against a timeline-based model.
module tb_fir_seq_ctrl;

    localparam int NT = 8;
    localparam int QD = 16;
    localparam int FL = 1;

    logic               clk;
    logic               rst;
    logic               smpl_rdy;
    logic               q_full;
    logic [3:0]         wr_ptr;
    logic               clr_ovr;
    logic signed [15:0] fir_out;
    logic               sequencing;
    logic [3:0]         rd_addr;
    logic signed [15:0] smpl_out;
    logic               smpl_vld;
    logic               busy;
    logic               overrun;

    int total = 0;
    int bad   = 0;

    fir_seq_ctrl #(.NTAPS(NT), .QDEPTH(QD), .FIR_LAT(FL)) dut (
        .clk        (clk),
        .rst        (rst),
        .smpl_rdy   (smpl_rdy),
        .q_full     (q_full),
        .wr_ptr     (wr_ptr),
        .clr_ovr    (clr_ovr),
        .fir_out    (fir_out),
        .sequencing (sequencing),
        .rd_addr    (rd_addr),
        .smpl_out   (smpl_out),
        .smpl_vld   (smpl_vld),
        .busy       (busy),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic signed [15:0] fo(input int c);
        return 16'(c * 37 + 5);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; smpl_rdy = 1'b0; clr_ovr = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({sequencing, busy, smpl_vld, overrun} !== 4'b0000) begin
            bad++; $display("FAIL reset_ctl: got %b want 0000", {sequencing, busy, smpl_vld, overrun});
        end
        total++;
        if (rd_addr !== 4'd0) begin bad++; $display("FAIL reset_addr: got %0d want 0", rd_addr); end
        total++;
        if (smpl_out !== 16'sd0) begin bad++; $display("FAIL reset_out: got %h want 0", smpl_out); end
    endtask

    task automatic test_fill();
        q_full = 1'b0;
        for (int i = 0; i < 20; i++) begin
            smpl_rdy = (i % 4 == 0);
            wr_ptr   = 4'(i);
            tick();
            total++;
            if (sequencing !== 1'b0 || busy !== 1'b0) begin
                bad++; $display("FAIL fill_idle: got seq=%b busy=%b want 0 0", sequencing, busy);
            end
        end
        smpl_rdy = 1'b0;
        total++;
        if (overrun !== 1'b0) begin bad++; $display("FAIL fill_ovr: got %b want 0", overrun); end
    endtask

    task automatic test_run(input logic [3:0] ptr, input logic signed [15:0] val, input string tag);
        logic [3:0] ea;
        q_full = 1'b1; wr_ptr = ptr; fir_out = val; smpl_rdy = 1'b1;
        tick();
        smpl_rdy = 1'b0; wr_ptr = 4'd0;
        for (int c = 1; c <= 13; c++) begin
            ea = (c <= NT) ? 4'(ptr + c - 1) : 4'(ptr + NT - 1);
            total++;
            if (sequencing !== (c <= NT)) begin
                bad++; $display("FAIL %s_seq c%0d: got %b want %b", tag, c, sequencing, (c <= NT));
            end
            total++;
            if (busy !== (c <= NT + FL + 1)) begin
                bad++; $display("FAIL %s_busy c%0d: got %b want %b", tag, c, busy, (c <= NT + FL + 1));
            end
            total++;
            if (rd_addr !== ea) begin
                bad++; $display("FAIL %s_addr c%0d: got %0d want %0d", tag, c, rd_addr, ea);
            end
            total++;
            if (smpl_vld !== (c == NT + FL + 2)) begin
                bad++; $display("FAIL %s_vld c%0d: got %b want %b", tag, c, smpl_vld, (c == NT + FL + 2));
            end
            if (c >= NT + FL + 2) begin
                total++;
                if (smpl_out !== val) begin
                    bad++; $display("FAIL %s_out c%0d: got %h want %h", tag, c, smpl_out, val);
                end
            end
            tick();
        end
    endtask

    task automatic pend_scn(input bit third, input string tag);
        logic [3:0] p2, ea;
        logic       eseq, ebusy, evld, eovr;
        p2 = third ? 4'd6 : 4'd4;
        q_full = 1'b1; wr_ptr = 4'd3; smpl_rdy = 1'b1; fir_out = fo(0);
        tick();
        for (int c = 1; c <= 23; c++) begin
            eseq  = (c >= 1 && c <= 8) || (c >= 11 && c <= 18);
            ebusy = (c >= 1 && c <= 20);
            evld  = (c == 11) || (c == 21);
            eovr  = third && (c >= 8);
            if (c <= 8)       ea = 4'(3 + c - 1);
            else if (c <= 10) ea = 4'd10;
            else if (c <= 18) ea = 4'(p2 + c - 11);
            else              ea = 4'(p2 + 7);
            total++;
            if (sequencing !== eseq) begin bad++; $display("FAIL %s_seq c%0d: got %b want %b", tag, c, sequencing, eseq); end
            total++;
            if (busy !== ebusy) begin bad++; $display("FAIL %s_busy c%0d: got %b want %b", tag, c, busy, ebusy); end
            total++;
            if (rd_addr !== ea) begin bad++; $display("FAIL %s_addr c%0d: got %0d want %0d", tag, c, rd_addr, ea); end
            total++;
            if (smpl_vld !== evld) begin bad++; $display("FAIL %s_vld c%0d: got %b want %b", tag, c, smpl_vld, evld); end
            total++;
            if (overrun !== eovr) begin bad++; $display("FAIL %s_ovr c%0d: got %b want %b", tag, c, overrun, eovr); end
            if (c >= 11) begin
                total++;
                if (smpl_out !== ((c >= 21) ? fo(20) : fo(10))) begin
                    bad++; $display("FAIL %s_out c%0d: got %h want %h", tag, c, smpl_out, ((c >= 21) ? fo(20) : fo(10)));
                end
            end
            smpl_rdy = (c == 5) || (third && c == 7);
            wr_ptr   = (c == 5) ? 4'd4 : 4'd6;
            fir_out  = fo(c);
            tick();
        end
        smpl_rdy = 1'b0;
    endtask

    task automatic test_single();  test_run(4'd3, 16'sh1234, "single"); endtask
    task automatic test_wrap();    test_run(4'd12, -16'sd77, "wrap"); endtask
    task automatic test_pending(); pend_scn(1'b0, "pend"); endtask
    task automatic test_overrun(); pend_scn(1'b1, "ovr"); endtask

    task automatic test_ovr_clear();
        smpl_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_hold: got %b want 1", overrun); end
        end
        clr_ovr = 1'b1; tick(); clr_ovr = 1'b0;
        total++;
        if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_clr: got %b want 0", overrun); end
        q_full = 1'b1; wr_ptr = 4'd0; smpl_rdy = 1'b1;
        tick();
        smpl_rdy = 1'b0;
        tick();
        smpl_rdy = 1'b1; wr_ptr = 4'd1;
        tick();
        total++;
        if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_first_pend: got %b want 0", overrun); end
        smpl_rdy = 1'b1; wr_ptr = 4'd2; clr_ovr = 1'b1;
        tick();
        total++;
        if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_set_vs_clr: got %b want 1", overrun); end
        smpl_rdy = 1'b0; clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        total++;
        if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_clr2: got %b want 0", overrun); end
        do_reset();
    endtask

    task automatic test_reset_mid();
        q_full = 1'b1; wr_ptr = 4'd5; smpl_rdy = 1'b1;
        tick();
        smpl_rdy = 1'b0;
        tick(); tick(); tick();
        total++;
        if (sequencing !== 1'b1 || rd_addr !== 4'd8) begin
            bad++; $display("FAIL midrst_pre: got seq=%b addr=%0d want 1 8", sequencing, rd_addr);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if ({sequencing, busy, smpl_vld, overrun} !== 4'b0000) begin
            bad++; $display("FAIL midrst_ctl: got %b want 0000", {sequencing, busy, smpl_vld, overrun});
        end
        total++;
        if (rd_addr !== 4'd0 || smpl_out !== 16'sd0) begin
            bad++; $display("FAIL midrst_data: got addr=%0d out=%h want 0 0", rd_addr, smpl_out);
        end
        for (int i = 0; i < 12; i++) begin
            tick();
            total++;
            if (smpl_vld !== 1'b0 || busy !== 1'b0) begin
                bad++; $display("FAIL midrst_quiet: got vld=%b busy=%b want 0 0", smpl_vld, busy);
            end
        end
        test_run(4'd3, 16'sh1234, "after_rst");
    endtask

    task automatic test_random();
        bit                 active, pend, ovr, vld, eseq, capt, cons, setov;
        bit                 r_rdy, r_qf, r_clr, r_rst;
        int                 b, ptr, pptr, off;
        logic [3:0]         last_addr, ea, r_wp;
        logic signed [15:0] oreg, r_fo;
        do_reset();
        active = 0; pend = 0; ovr = 0; vld = 0; b = 0; ptr = 0; pptr = 0;
        last_addr = 4'd0; oreg = 16'sd0;
        for (int n = 0; n < 2000; n++) begin
            off  = n - b;
            eseq = active && (off < NT);
            ea   = eseq ? 4'((ptr + off) % QD) : last_addr;
            total++;
            if (sequencing !== eseq) begin bad++; $display("FAIL rnd_seq n%0d: got %b want %b", n, sequencing, eseq); end
            total++;
            if (busy !== active) begin bad++; $display("FAIL rnd_busy n%0d: got %b want %b", n, busy, active); end
            total++;
            if (rd_addr !== ea) begin bad++; $display("FAIL rnd_addr n%0d: got %0d want %0d", n, rd_addr, ea); end
            total++;
            if (smpl_vld !== vld) begin bad++; $display("FAIL rnd_vld n%0d: got %b want %b", n, smpl_vld, vld); end
            total++;
            if (smpl_out !== oreg) begin bad++; $display("FAIL rnd_out n%0d: got %h want %h", n, smpl_out, oreg); end
            total++;
            if (overrun !== ovr) begin bad++; $display("FAIL rnd_ovr n%0d: got %b want %b", n, overrun, ovr); end

            r_rdy = ($urandom_range(0, 9) < 3);
            r_qf  = ($urandom_range(0, 99) < 85);
            r_clr = ($urandom_range(0, 19) == 0);
            r_rst = ($urandom_range(0, 299) == 0);
            r_wp  = 4'($urandom_range(0, 15));
            r_fo  = 16'($urandom);
            smpl_rdy = r_rdy; q_full = r_qf; clr_ovr = r_clr; rst = r_rst;
            wr_ptr = r_wp; fir_out = r_fo;

            if (eseq) last_addr = ea;
            capt = active && (off == NT + FL);
            vld  = capt;
            if (capt) oreg = r_fo;
            setov = 0;
            if (r_rst) begin
                active = 0; pend = 0; ovr = 0; vld = 0; oreg = 16'sd0; last_addr = 4'd0;
            end else begin
                if (!active) begin
                    if (pend) begin
                        active = 1; b = n + 1; ptr = pptr; pend = 0;
                        if (r_rdy) begin pend = 1; pptr = r_wp; end
                    end else if (r_rdy && r_qf) begin
                        active = 1; b = n + 1; ptr = r_wp;
                    end
                end else begin
                    cons  = capt && pend;
                    setov = r_rdy && pend && !cons;
                    if (capt) begin
                        if (pend) begin b = n + 1; ptr = pptr; pend = 0; end
                        else      active = 0;
                    end
                    if (r_rdy) begin pend = 1; pptr = r_wp; end
                end
                if (setov)      ovr = 1;
                else if (r_clr) ovr = 0;
            end
            tick();
        end
        rst = 1'b0; smpl_rdy = 1'b0; clr_ovr = 1'b0;
    endtask

    initial begin
        rst = 1'b1; smpl_rdy = 1'b0; q_full = 1'b0; wr_ptr = 4'd0;
        clr_ovr = 1'b0; fir_out = 16'sd0;
        test_reset();
        test_fill();
        test_single();
        test_wrap();
        test_pending();
        test_reset_mid();
        test_overrun();
        test_ovr_clear();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
